// File: rtl/rob_entry_structs.sv
// Reorder-buffer entry and retire-port records plus ROB default sizing.
package rob_entry_structs;

  localparam int ROB_DEPTH_DEF    = 32;
  localparam int ROB_COMMIT_W_DEF = 2;
  parameter  int ROB_IDX_W        = $clog2(ROB_DEPTH_DEF);
  // Width of a per-cycle retire count; holds 0..4.
  localparam int CNT_W            = 3;

  typedef struct packed {
    logic                          valid;
    logic                          done;
    logic [4:0]                    rd;
    logic [rv_structs::DATA_W-1:0] value;
  } rob_entry_t;

  typedef struct packed {
    logic                          valid;
    logic [rv_structs::DATA_W-1:0] value;
    logic [ROB_IDX_W-1:0]          rob_idx;
    logic [4:0]                    regfile_idx;
  } rob_commit_t;

endpackage

// File: rtl/rv_structs.sv
// Shared RISC-V pipeline types: common-data-bus broadcast record.
package rv_structs;

  localparam int DATA_W    = 32;
  localparam int ROB_TAG_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [ROB_TAG_W-1:0] dest_rob;
    logic [DATA_W-1:0]    value;
  } data_bus;

endpackage

// File: rtl/rob_multi_if.sv
// Issue / CDB / retire bundle of the reorder buffer. The flush signal exists
// only when ROB_FLUSH_EN is defined.
interface rob_multi_if
  import rv_structs::*, rob_entry_structs::*;
#(
  parameter int NUM_CDB  = 5,
  parameter int COMMIT_W = 2,
  parameter int IDX_W    = 5
) ();

  logic                       issue;
  logic [4:0]                 DR_entry_issue;
  logic [IDX_W-1:0]           issue_rob_idx;
  data_bus     [NUM_CDB-1:0]  bus;
  logic                       commit;
  logic                       cir_q_full;
  logic                       cir_q_empty;
  rob_commit_t [COMMIT_W-1:0] rob_regfile_bus;
`ifdef ROB_FLUSH_EN
  logic                       flush;
`endif

  modport master (
`ifdef ROB_FLUSH_EN
    output flush,
`endif
    output issue, DR_entry_issue, bus, commit,
    input  issue_rob_idx, cir_q_full, cir_q_empty, rob_regfile_bus
  );

  modport slave (
`ifdef ROB_FLUSH_EN
    input  flush,
`endif
    input  issue, DR_entry_issue, bus, commit,
    output issue_rob_idx, cir_q_full, cir_q_empty, rob_regfile_bus
  );

endinterface

// File: rtl/rob_commit_select.sv
// Counts consecutive valid-and-done entries starting at head (with wrap),
// capped at COMMIT_W. Purely combinational.
module rob_commit_select
  import rob_entry_structs::*;
#(
  parameter int DEPTH    = 32,
  parameter int COMMIT_W = 2,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic [IDX_W-1:0] head_i,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [DEPTH-1:0] done_i,
  output logic [CNT_W-1:0] n_o
);

  logic             run;
  logic [IDX_W-1:0] idx;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    n_o = '0;
    run = 1'b1;
    idx = head_i;
    for (int i = 0; i < COMMIT_W; i++) begin
      idx = head_i + IDX_W'(i);
      if (run && valid_i[idx] && done_i[idx]) begin
        n_o = n_o + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multi.sv
// Multi-commit reorder buffer: in-order allocate, out-of-order CDB capture,
// up to COMMIT_W in-order retirements per cycle. Optional flush: ROB_FLUSH_EN.
module rob_multi
  import rv_structs::*, rob_entry_structs::*;
#(
  parameter int DEPTH    = ROB_DEPTH_DEF,
  parameter int NUM_CDB  = 5,
  parameter int COMMIT_W = ROB_COMMIT_W_DEF,
  parameter int XLEN     = 32,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst,
  rob_multi_if.slave rob
);

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [4:0]       rd_q  [DEPTH];
  logic [4:0]       rd_d  [DEPTH];
  logic [XLEN-1:0]  val_q [DEPTH];
  logic [XLEN-1:0]  val_d [DEPTH];

  rob_commit_t [COMMIT_W-1:0] slot_q, slot_d;

  logic             full;
  logic             empty;
  logic             issue_ok;
  logic [CNT_W-1:0] n_sel;
  logic [CNT_W-1:0] n_ret;
  logic [IDX_W-1:0] bidx;
  logic [IDX_W-1:0] cidx;

  assign full  = (count_q == (IDX_W+1)'(DEPTH));
  assign empty = (count_q == '0);

  rob_commit_select #(
    .DEPTH    (DEPTH),
    .COMMIT_W (COMMIT_W),
    .IDX_W    (IDX_W)
  ) u_commit_select (
    .head_i  (head_q),
    .valid_i (valid_q),
    .done_i  (done_q),
    .n_o     (n_sel)
  );

  // Eligibility uses pre-edge done flags, so a same-cycle broadcast to head
  // only makes it retirable on the following cycle.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    valid_d  = valid_q;
    done_d   = done_q;
    rd_d     = rd_q;
    val_d    = val_q;
    slot_d   = '0;
    bidx     = '0;
    cidx     = head_q;
    issue_ok = rob.issue && !full;
    n_ret    = rob.commit ? n_sel : '0;

    // Later buses overwrite earlier ones, so the highest index wins.
    for (int k = 0; k < NUM_CDB; k++) begin
      bidx = IDX_W'(rob.bus[k].dest_rob);
      if (rob.bus[k].valid && valid_q[bidx]) begin
        done_d[bidx] = 1'b1;
        val_d[bidx]  = XLEN'(rob.bus[k].value);
      end
    end

    for (int i = 0; i < COMMIT_W; i++) begin
      cidx = head_q + IDX_W'(i);
      if (CNT_W'(i) < n_ret) begin
        valid_d[cidx]            = 1'b0;
        done_d[cidx]             = 1'b0;
        slot_d[i].valid          = 1'b1;
        slot_d[i].value          = DATA_W'(val_q[cidx]);
        slot_d[i].rob_idx        = ROB_IDX_W'(cidx);
        slot_d[i].regfile_idx    = rd_q[cidx];
      end
    end
    head_d = head_q + IDX_W'(n_ret);

    if (issue_ok) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      rd_d[tail_q]    = rob.DR_entry_issue;
      val_d[tail_q]   = '0;
      tail_d          = tail_q + IDX_W'(1);
    end

    count_d = count_q + (IDX_W+1)'(issue_ok) - (IDX_W+1)'(n_ret);

`ifdef ROB_FLUSH_EN
    if (rob.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      slot_d  = '0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      slot_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      slot_q  <= slot_d;
    end
  end

  // NOTE: the payload array is deliberately not reset; valid/done gate every
  // read, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    val_q <= val_d;
  end

  assign rob.issue_rob_idx   = tail_q;
  assign rob.cir_q_full      = full;
  assign rob.cir_q_empty     = empty;
  assign rob.rob_regfile_bus = slot_q;

endmodule

// File: doc/rob_multi.md
# rob_multi

Parametrised reorder buffer, successor to the single-commit 32-entry ROB. It allocates entries in program order from the issue stage and captures results from NUM_CDB common-data-bus broadcasts in any order. It retires up to COMMIT_W consecutive completed head entries per cycle to the regfile. It sits between the issue queue / reservation stations and the architectural register file.

## Interface
Parameters:
- DEPTH, 32, number of entries; must be a power of two, at least 4
- NUM_CDB, 5, number of CDB broadcast ports
- COMMIT_W, 2, maximum retirements per cycle; range 1..4
- XLEN, 32, data width
- IDX_W, $clog2(DEPTH), ROB index width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- issue  in  1  allocate one entry at the tail this cycle
- DR_entry_issue  in  5  destination architectural register of the issuing instruction
- issue_rob_idx  out  IDX_W  current tail index (tag for the issuing instruction); combinational from tail
- bus  in  NUM_CDB x rv_structs::data_bus  CDB broadcasts {valid, dest_rob, value}
- commit  in  1  retire enable
- cir_q_full  out  1  count == DEPTH
- cir_q_empty  out  1  count == 0
- rob_regfile_bus  out  COMMIT_W x rob_commit_t  registered retire ports {valid, value, rob_idx, regfile_idx}; slot 0 is the oldest
- flush  in  1  present only with ROB_FLUSH_EN

## Operation
- State:
  - entry array {valid, done, rd, value}
  - head, tail (IDX_W bits, wrap mod DEPTH)
  - count (IDX_W+1 bits)
- Reset (async):
  - all entries invalid; head = tail = count = 0
  - cir_q_empty = 1, cir_q_full = 0
  - all rob_regfile_bus slots zero (valid = 0)
- Issue:
  - if issue && !cir_q_full (pre-edge), write entry[tail] = {1, 0, DR_entry_issue, 0} and advance tail
  - if issue && cir_q_full, the request is dropped silently; no state change
- Broadcast: for each bus[k].valid, if entry[dest_rob].valid, set done = 1 and value = bus[k].value.
  - broadcast to an invalid entry: ignored
  - two buses targeting the same entry in one cycle: the highest k wins
  - re-broadcast to a done entry overwrites value
- Commit: when commit = 1, n = number of consecutive entries from head with valid && done (stored pre-edge state), capped at COMMIT_W.
  - those entries are invalidated; head += n (mod DEPTH)
  - slot i output = {1, value, head+i, rd} for i < n; remaining slots have valid = 0
  - a broadcast in the same cycle to the head entry does not make it eligible until the next cycle
  - n = 0 (head not done, or ROB empty): all slots invalid
- Count: count_next = count + issue_accepted − n.
  - issue and commit in the same cycle while full: issue is still rejected, because full is evaluated pre-edge
- rd = 0 entries commit normally with regfile_idx = 0; the regfile discards the write.

## Timing
- Issue: entry is valid at the next edge; cir_q_empty/cir_q_full reflect the new count 1 cycle after the issue edge.
- Broadcast: done flag is set at the edge; earliest retire is a commit sampled at the following edge.
- Commit: rob_regfile_bus slots are valid for exactly 1 cycle after the edge that sampled commit; with commit low they are deasserted the next cycle.
- Wrap-around: indices roll DEPTH−1 → 0 with no bubble. Full and empty are distinguished by count, not by pointer compare.
- No combinational path from bus or commit to any output. issue_rob_idx depends on tail only.

## Configuration
- ROB_FLUSH_EN defined: flush port exists.
  - flush = 1 at an edge: invalidates all entries, head = tail = count = 0, all commit slots valid = 0
  - flush has priority over same-cycle issue, broadcast and commit
- ROB_FLUSH_EN undefined: no flush port and no flush logic; the ROB is cleared only by rst.

## Structure
- rob_entry_structs package holds rob_entry_t and rob_commit_t (rob_idx widened to IDX_W via package parameter ROB_IDX_W), plus constants ROB_DEPTH_DEF and ROB_COMMIT_W_DEF.
- rv_structs::data_bus is reused unchanged for the CDB.
- Sub-module rob_commit_select: given the head index and the valid/done vectors, returns n (leading-done count from head with wrap, capped at COMMIT_W). It is combinational and instantiated once.

## Test plan
- Reset → cir_q_empty = 1, cir_q_full = 0, all rob_regfile_bus.valid = 0, issue_rob_idx = 0.
- 32 issues with DR_entry_issue = i → cir_q_full = 1; a 33rd issue with DR_entry_issue = 7 → no change, tail still 0.
- In-order: broadcast rob 0..4 with value 200+i, then commit for 3 cycles (COMMIT_W = 2) → retire (0,1), (2,3), (4), each with value 200+i and regfile_idx i; afterwards cir_q_full = 0.
- Out-of-order: broadcast 8, 14, 7, 12, 5 on buses 0..4 in one cycle, then 6, 9, 11, 13, 10 → committing retires 5..14 strictly in index order, two per cycle, value 200+i.
- Wrap: after head passes 31, issue 5 more entries → issue_rob_idx goes 0..4 following 31; broadcast and commit yield rob_idx 0..4 with the correct rd.
- Same-cycle cases: a broadcast to head together with commit → no retire that cycle, retire on the next commit. With ROB_FLUSH_EN, flush together with issue → cir_q_empty = 1 and no commit valid.
